// File: rtl/simple_err_mem_stream_ctrl_if.sv
// Stream and single-port memory signals of the FIFO controller.
// The master side is the controller. The slave side is the environment: upstream, downstream and memory.
interface simple_err_mem_stream_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [WIDTH-1:0]  mem_wr_data;
  logic [WIDTH-1:0]  mem_rd_data;

  modport master (
    input  in_valid, in_data, out_ready, mem_rd_data,
    output in_ready, out_valid, out_data, mem_addr, mem_wr_en, mem_rd_en, mem_wr_data
  );

  modport slave (
    output in_valid, in_data, out_ready, mem_rd_data,
    input  in_ready, out_valid, out_data, mem_addr, mem_wr_en, mem_rd_en, mem_wr_data
  );
endinterface

// File: rtl/simple_err_mem_stream_ctrl.sv
// FIFO controller that uses an external single-port memory as storage.
// A 2-entry output buffer absorbs the memory's 1-cycle read latency.
module simple_err_mem_stream_ctrl #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64   // must equal 2**ADDR_W
) (
  input  logic                                clk,
  input  logic                                reset,
  simple_err_mem_stream_ctrl_if.master        bus,
  output logic [ADDR_W:0]                     level
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  mem_count_q, mem_count_d;
  logic              rd_inflight_q, rd_inflight_d;
  logic [1:0]        obuf_cnt_q, obuf_cnt_d;
  logic [WIDTH-1:0]  obuf_q [2];
  logic [WIDTH-1:0]  obuf_d [2];

  logic       pop;
  logic       push;
  logic       rd_go;
  logic       wr_go;
  logic [2:0] obuf_demand;
  logic [1:0] tail;

  // Port arbitration: a read wins whenever the output buffer has room for its return.
  always_comb begin
    pop         = reset && (obuf_cnt_q != 2'd0) && bus.out_ready;
    push        = rd_inflight_q;
    obuf_demand = {1'b0, obuf_cnt_q} + {2'b00, rd_inflight_q};
    rd_go       = reset && (mem_count_q != '0) && (obuf_demand < (3'd2 + {2'b00, pop}));
    wr_go       = reset && !rd_go && (mem_count_q < FULL) && bus.in_valid;
  end

  assign bus.in_ready    = reset && !rd_go && (mem_count_q < FULL);
  assign bus.out_valid   = reset && (obuf_cnt_q != 2'd0);
  assign bus.out_data    = obuf_q[0];
  assign bus.mem_rd_en   = rd_go;
  assign bus.mem_wr_en   = wr_go;
  assign bus.mem_wr_data = bus.in_data;
  assign bus.mem_addr    = !reset ? '0 : (rd_go ? rd_ptr_q : wr_ptr_q);

  assign level = reset ? (mem_count_q + CNT_W'(rd_inflight_q) + CNT_W'(obuf_cnt_q)) : '0;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a value held (no latch).
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_count_d   = mem_count_q;
    rd_inflight_d = rd_go;
    obuf_cnt_d    = obuf_cnt_q - {1'b0, pop} + {1'b0, push};
    obuf_d        = obuf_q;
    tail          = obuf_cnt_q - {1'b0, pop};

    if (wr_go) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      mem_count_d = mem_count_q + 1'b1;
    end
    if (rd_go) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      mem_count_d = mem_count_q - 1'b1;
    end

    // Pop shifts the head out first; a returning read then lands behind whatever remains.
    if (pop) begin
      obuf_d[0] = obuf_q[1];
    end
    if (push) begin
      obuf_d[tail[0]] = bus.mem_rd_data;
    end
  end

  // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_count_q   <= '0;
      rd_inflight_q <= 1'b0;
      obuf_cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_count_q   <= mem_count_d;
      rd_inflight_q <= rd_inflight_d;
      obuf_cnt_q    <= obuf_cnt_d;
    end
  end

  // NOTE: buffer storage is not reset; obuf_cnt_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    obuf_q <= obuf_d;
  end

endmodule

// File: tb/tb_simple_err_mem_stream_ctrl.sv
// Self-checking bench: a behavioural memory plus a word-count and queue model of the FIFO.
// Directed phases are followed by a random out_ready phase.
module tb_simple_err_mem_stream_ctrl;

  logic clk;
  logic reset;
  logic [6:0] level;

  simple_err_mem_stream_ctrl_if #(.WIDTH(32), .ADDR_W(6)) bus ();

  simple_err_mem_stream_ctrl #(.WIDTH(32), .ADDR_W(6), .DEPTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .level (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory with 1-cycle read latency; data is X when no read was issued.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
    bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_addr] : 'x;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Model state: counts of words accepted, read from memory and delivered, plus the expected order.
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          pop_cnt = 0;
  int          infl = 0;
  int          total_acc = 0;
  logic [31:0] q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check the combinational response, advance the model at the edge.
  task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy, input logic rst);
    int   mcnt;
    int   ob;
    logic pop_m;
    logic exp_rd;
    logic exp_wr;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    reset         = rst;
    #1;
    mcnt   = wr_cnt - rd_cnt;
    ob     = rd_cnt - pop_cnt - infl;
    pop_m  = 1'b0;
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    check("excl_strobes", 64'(bus.mem_wr_en & bus.mem_rd_en), 64'd0);
    if (!rst) begin
      check("rst_in_ready",  64'(bus.in_ready),  64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_wr_en",     64'(bus.mem_wr_en), 64'd0);
      check("rst_rd_en",     64'(bus.mem_rd_en), 64'd0);
      check("rst_addr",      64'(bus.mem_addr),  64'd0);
      check("rst_level",     64'(level),         64'd0);
    end else begin
      pop_m  = (ob != 0) && ordy;
      exp_rd = (mcnt != 0) && ((ob + infl - int'(pop_m)) < 2);
      exp_wr = !exp_rd && (mcnt < 64) && iv;
      check("obuf_max",  64'(ob > 2),           64'd0);
      check("out_valid", 64'(bus.out_valid),    64'(ob != 0));
      check("rd_en",     64'(bus.mem_rd_en),    64'(exp_rd));
      check("in_ready",  64'(bus.in_ready),     64'(!exp_rd && (mcnt < 64)));
      check("wr_en",     64'(bus.mem_wr_en),    64'(exp_wr));
      check("addr",      64'(bus.mem_addr),     64'(exp_rd ? (rd_cnt % 64) : (wr_cnt % 64)));
      check("level",     64'(level),            64'(wr_cnt - pop_cnt));
      if (exp_wr) check("wr_data", 64'(bus.mem_wr_data), 64'(id));
      if (pop_m && q.size() > 0) check("out_data", 64'(bus.out_data), 64'(q[0]));
    end
    @(posedge clk);
    if (!rst) begin
      wr_cnt = 0; rd_cnt = 0; pop_cnt = 0; infl = 0;
      q.delete();
    end else begin
      if (exp_wr) begin
        q.push_back(id);
        wr_cnt++;
        total_acc++;
      end
      if (exp_rd) rd_cnt++;
      infl = int'(exp_rd);
      if (pop_m) begin
        if (q.size() > 0) void'(q.pop_front());
        pop_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] d, input logic ordy);
    int start;
    start = total_acc;
    for (int c = 0; c < 20 && total_acc == start; c++) cycle(1'b1, d, ordy, 1'b1);
    check("push_accepted", 64'(total_acc - start), 64'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int c = 0; c < n; c++) cycle(1'b0, 32'h0, ordy, 1'b1);
  endtask

  initial begin
    int          start;
    logic [31:0] seq;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    seq           = 32'h1000;
    @(negedge clk);

    // Reset held for 3 cycles, then released idle.
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    check("t1_in_ready",  64'(bus.in_ready),  64'd1);
    check("t1_out_valid", 64'(bus.out_valid), 64'd0);
    check("t1_level",     64'(level),         64'd0);
    @(negedge clk);

    // Three words with the output stalled, then drained in order.
    push_word(32'h11, 1'b0);
    push_word(32'h22, 1'b0);
    push_word(32'h33, 1'b0);
    idle(4, 1'b0);
    #1;
    check("t2_out_valid", 64'(bus.out_valid), 64'd1);
    check("t2_head",      64'(bus.out_data),  64'h11);
    check("t2_level",     64'(level),         64'd3);
    check("t2_rd_idle",   64'(bus.mem_rd_en), 64'd0);
    @(negedge clk);
    idle(6, 1'b1);
    #1;
    check("t2_empty", 64'(bus.out_valid), 64'd0);
    @(negedge clk);

    // Fill to capacity with the output stalled.
    for (int c = 0; c < 200; c++) begin
      cycle(1'b1, seq, 1'b0, 1'b1);
      seq++;
    end
    #1;
    check("t3_level",    64'(level),         64'd66);
    check("t3_in_ready", 64'(bus.in_ready),  64'd0);
    check("t3_no_write", 64'(bus.mem_wr_en), 64'd0);
    @(negedge clk);
    idle(100, 1'b1);

    // 200 sequential words with the output always ready; pointers wrap.
    start = total_acc;
    for (int c = 0; c < 1000 && (total_acc - start) < 200; c++) begin
      cycle(1'b1, seq, 1'b1, 1'b1);
      if (total_acc != start) seq = 32'h2000 + 32'(total_acc - start);
    end
    check("t4_accepted", 64'(total_acc - start), 64'd200);
    idle(10, 1'b1);
    check("t4_drained", 64'(pop_cnt), 64'(wr_cnt));

    // Random out_ready with input always offered.
    for (int c = 0; c < 400; c++) begin
      cycle(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    end
    idle(100, 1'b1);
    check("t5_drained", 64'(pop_cnt), 64'(wr_cnt));

    // Reset right after a read issue: the returning word must be dropped.
    for (int i = 0; i < 6; i++) push_word(32'hA0 + 32'(i), 1'b0);
    idle(4, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    check("t6_read_issued", 64'(bus.mem_rd_en), 64'd1);
    check("t6_level_pre",   64'(level),         64'd6);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'hABCD, 1'b0, 1'b1);
    idle(3, 1'b0);
    #1;
    check("t6_new_head",  64'(bus.out_data), 64'hABCD);
    check("t6_level_post", 64'(level),       64'd1);
    @(negedge clk);
    idle(3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/simple_err_mem_stream_ctrl.md
Name: simple_err_mem_stream_ctrl

Overview:
Initiator side of the single-port memory interface: drives address, read and write strobes, and write data into a memory_32_6-style memory instance, and consumes its read data. Uses that memory as a 64-entry FIFO between a valid/ready input stream and a valid/ready output stream. Arbitrates the single port between reads and writes and absorbs the 1-cycle read latency with a 2-entry output buffer.

Parameters:
WIDTH, 32, data width of streams and memory word
ADDR_W, 6, memory address width
DEPTH, 64, FIFO capacity in words; must equal 2**ADDR_W

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  input word present
in_ready  output  1  controller accepts input word this cycle
in_data  input  WIDTH  input word
out_valid  output  1  output word present
out_ready  input  1  downstream accepts output word
out_data  output  WIDTH  output word (head of output buffer)
mem_addr  output  ADDR_W  memory address for this cycle's access
mem_wr_en  output  1  memory write strobe
mem_rd_en  output  1  memory read strobe
mem_wr_data  output  WIDTH  memory write data (equals in_data)
mem_rd_data  input  WIDTH  memory read data, valid 1 cycle after mem_rd_en
level  output  ADDR_W+1  number of words held (memory + in flight + output buffer)

Behaviour:
- Reset (reset==0 at a clk edge): wr_ptr=0, rd_ptr=0, mem_count=0, rd_inflight=0, output buffer emptied. While reset is low: in_ready=0, out_valid=0, mem_wr_en=0, mem_rd_en=0, mem_addr=0, level=0. A read in flight when reset asserts is discarded; its returning data is not captured.
- mem_count: words written to memory but not yet read, range 0..DEPTH. obuf_cnt: output buffer occupancy, 0..2. rd_inflight: 1 if mem_rd_en was asserted the previous cycle.
- Read issue (combinational): rd_go = (mem_count != 0) && (obuf_cnt + rd_inflight - (out_valid && out_ready) < 2). When rd_go=1: mem_rd_en=1, mem_addr=rd_ptr; at the edge rd_ptr++ and mem_count--.
- Write: in_ready = !rd_go && (mem_count < DEPTH) && reset. Read has priority on the port. On in_valid && in_ready: mem_wr_en=1, mem_addr=wr_ptr, mem_wr_data=in_data; at the edge wr_ptr++ and mem_count++.
- Reads and writes never occur in the same cycle. mem_wr_en and mem_rd_en are mutually exclusive.
- When neither read nor write occurs: mem_addr=wr_ptr, both strobes are 0.
- Read return: the cycle after rd_go, mem_rd_data is pushed into the output buffer tail. Pushing and popping (out_valid && out_ready) in the same cycle are both honoured.
- out_valid = (obuf_cnt != 0); out_data = buffer head. Words appear in the same order they were accepted.
- Latency: a word written into an empty FIFO at edge N is read at N+1 and reaches out_valid after edge N+2 (3 cycles from acceptance).
- Throughput: output of 1 word/cycle when out_ready=1 and the FIFO is non-empty. While reads are continuously eligible, input is stalled. Writes resume when mem_count==0 or the output buffer is full.
- Pointers wrap modulo DEPTH without special handling. Full is mem_count==DEPTH; empty is mem_count==0. Pointers alone never decide full or empty.
- level = mem_count + rd_inflight + obuf_cnt. Maximum value is DEPTH+2.
- No output changes based on X from mem_rd_data unless rd_inflight==1.

Test Plan:
- Reset held low 3 cycles, then released with in_valid=0 -> out_valid=0, level=0, in_ready=1, no strobes.
- Write 0x11,0x22,0x33 with out_ready=0 -> addresses 0,1,2 written; 2 words are read back into the buffer, then reads stop; level=3; out_valid=1 with out_data=0x11. Raise out_ready -> 0x11,0x22,0x33 in order, then out_valid=0.
- Hold out_ready=0 and push 70 words -> after buffer fill, in_ready drops when mem_count=64; level=66; no mem_wr_en while full.
- Stream 200 sequential words with out_ready=1 -> in-order output, pointers wrap past 63, no word lost or duplicated.
- Toggle out_ready randomly at 50% with in_valid always 1 -> scoreboard match. Never mem_rd_en and mem_wr_en both high; obuf_cnt never exceeds 2.
- Assert reset in the cycle after mem_rd_en=1 with 5 words held -> next cycle level=0 and out_valid=0. The returning read is dropped, and the first post-reset write goes to address 0.
